fc1_tx_ordered_set_gen: RTL and testbench
=========================================

# fc1_tx_ordered_set_gen

FC-1 transmit word generator, the transmit-side counterpart of the FC-1 receive decode and statistics path in mtip_if. It drives one 32-bit word per clock toward the MoreThanIP transmit interface. It emits either the primitive sequence commanded by the link controller (NOS/OLS/LR/LRR) or, in ACTIVE mode, IDLE fill plus frames from an upstream frame source. It enforces the inter-frame IDLE gap and the minimum primitive-sequence length, and keeps interval statistics.

## Interface
- IDLE_GAP, 6, minimum number of fill words between an EOF word and the next SOF word (1..15)
- MIN_SEQ, 12, minimum number of consecutive output words in a newly entered mode before another mode change is honoured (1..255)
- clk  in  1  transmit clock
- rst_n  in  1  reset; asynchronous, active-low
- iTX_MODE  in  3  commanded mode: 0 ACTIVE, 1 NOS, 2 OLS, 3 LR, 4 LRR; values 5-7 are treated as NOS
- iFRM_VALID  in  1  frame word available
- iFRM_DATA  in  32  frame word; SOF/EOF delimiter words are supplied by the source
- iFRM_KCHN  in  1  word carries a K28.5 in [31:24]; delimiters only
- iFRM_SOF  in  1  word is the SOF delimiter
- iFRM_EOF  in  1  word is the EOF delimiter
- oFRM_READY  out  1  word is accepted when iFRM_VALID & oFRM_READY
- oTX_DATA  out  32  transmitted word; first byte in [31:24]
- oTX_KCHN  out  1  [31:24] is K28.5
- oFRM_UNDERRUN  out  1  one-cycle pulse: IDLE inserted mid-frame
- oFRM_PROTO_ERR  out  1  one-cycle pulse: first word of a frame lacked iFRM_SOF and was dropped
- iSTATS_LATCH_CLR  in  1  interval latch/clear strobe
- oINT_STATS_TX_FRAMES  out  32  frames completed in the last interval
- oINT_STATS_TX_PRIM_SEQ  out  32  primitive-sequence entries in the last interval

## Operation
- Fill encodings (oTX_KCHN=1):
  - IDLE = 32'hBC95B5B5
  - NOS = 32'hBC55BF45
  - OLS = 32'hBC358A55
  - LR = 32'hBC49BF49
  - LRR = 32'hBC35BF49
- Effective mode eff_mode:
  - Reset value NOS.
  - Takes iTX_MODE only when state is FILL and hold_cnt has reached MIN_SEQ.
  - On each change, hold_cnt is cleared to 0; it then counts output words and saturates at MIN_SEQ.
  - A request that is not honoured stays pending for as long as iTX_MODE holds it. It is not latched.
- States:
  - FILL: emit the fill word for eff_mode (IDLE when ACTIVE).
    - oFRM_READY = (eff_mode==ACTIVE) & (gap_cnt==IDLE_GAP) & (iTX_MODE==ACTIVE).
    - An accepted word with iFRM_SOF is emitted and the state moves to FRAME.
    - An accepted word without iFRM_SOF is dropped: IDLE is emitted, oFRM_PROTO_ERR pulses, the state stays FILL.
  - FRAME: oFRM_READY=1.
    - Each accepted word is emitted with oTX_KCHN=iFRM_KCHN.
    - If no word is accepted in a cycle, IDLE is emitted and oFRM_UNDERRUN pulses.
    - An accepted word with iFRM_EOF returns the state to FILL and clears gap_cnt to 0.
    - Mode changes are deferred until after the EOF: the frame always completes.
- gap_cnt:
  - Increments on every fill word emitted in FILL and saturates at IDLE_GAP.
  - Reset value 0, so IDLE_GAP fill words precede the first frame after reset or after leaving a primitive sequence.
- Statistics:
  - Frame counter increments on an accepted EOF word.
  - Primitive-sequence counter increments on each eff_mode change into NOS/OLS/LR/LRR, including changes between two primitive modes. The reset-entry into NOS is not counted.
  - On iSTATS_LATCH_CLR the output register loads count + this-cycle increment and the counter clears to 0.
  - Counters wrap at 2^32.
  - Output registers reset to 0.

## Timing
- Reset values:
  - oTX_DATA=0, oTX_KCHN=0
  - oFRM_READY=0, oFRM_UNDERRUN=0, oFRM_PROTO_ERR=0
  - both stats outputs 0
  - state FILL, eff_mode NOS, hold_cnt 0, gap_cnt 0
- First cycle after rst_n deasserts: NOS is emitted.
- oTX_DATA, oTX_KCHN and the error pulses are registered.
  - A word accepted in cycle N appears in cycle N+1.
  - A mode change honoured in cycle N shows its first fill word in cycle N+1.
- oFRM_READY is decoded from registered state only, never from iFRM_VALID.
- Continuous stream: exactly one word on oTX_DATA every cycle after reset.
- Simultaneous EOF acceptance and a non-ACTIVE iTX_MODE: the EOF word is emitted. The mode change is honoured on the next FILL cycle, provided hold_cnt has reached MIN_SEQ.
- Asynchronous reset mid-frame: the frame is abandoned and the block restarts in NOS. The source must resynchronise on SOF.

## Test plan
- Reset release, iTX_MODE=1: 32'hBC55BF45 every cycle from cycle 1; oFRM_READY=0 throughout.
- iTX_MODE 1 to 0 at cycle 20 (MIN_SEQ=12), frame SOF+3 words+EOF held valid:
  - IDLE 32'hBC95B5B5 from cycle 21
  - exactly 6 IDLEs, then 5 frame words back-to-back
  - next SOF no earlier than 6 IDLEs after the EOF
- iTX_MODE 0 to 3 while a frame is mid-payload: the frame completes through EOF, then 32'hBC49BF49. Switching to 4 two cycles later takes effect only after 12 LR words.
- iFRM_VALID dropped for 2 cycles mid-frame: 2 IDLE words inserted and oFRM_UNDERRUN pulses twice. First word without SOF: dropped, oFRM_PROTO_ERR pulses once.
- 3 frames, NOS to OLS to ACTIVE, then iSTATS_LATCH_CLR coincident with the third EOF: TX_FRAMES=3, TX_PRIM_SEQ=1. The next interval reads 0/0.
- rst_n asserted mid-frame: all outputs are 0 during reset and NOS follows. No stats increment until new activity.

Source files
------------

// File: rtl/fc1_tx_ordered_set_gen.sv
`timescale 1ns/1ps
// FC-1 transmit word generator: primitive sequences, IDLE fill,
// gap-limited frame pass-through and interval statistics.
module fc1_tx_ordered_set_gen #(
  parameter int unsigned IDLE_GAP = 6,
  parameter int unsigned MIN_SEQ  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  iTX_MODE,
  input  logic        iFRM_VALID,
  input  logic [31:0] iFRM_DATA,
  input  logic        iFRM_KCHN,
  input  logic        iFRM_SOF,
  input  logic        iFRM_EOF,
  output logic        oFRM_READY,
  output logic [31:0] oTX_DATA,
  output logic        oTX_KCHN,
  output logic        oFRM_UNDERRUN,
  output logic        oFRM_PROTO_ERR,
  input  logic        iSTATS_LATCH_CLR,
  output logic [31:0] oINT_STATS_TX_FRAMES,
  output logic [31:0] oINT_STATS_TX_PRIM_SEQ
);

  typedef enum logic [2:0] {
    M_ACT = 3'd0,
    M_NOS = 3'd1,
    M_OLS = 3'd2,
    M_LR  = 3'd3,
    M_LRR = 3'd4
  } mode_e;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_FRAME = 1'b1
  } state_e;

  localparam logic [31:0] W_IDLE = 32'hBC95B5B5;
  localparam logic [31:0] W_NOS  = 32'hBC55BF45;
  localparam logic [31:0] W_OLS  = 32'hBC358A55;
  localparam logic [31:0] W_LR   = 32'hBC49BF49;
  localparam logic [31:0] W_LRR  = 32'hBC35BF49;

  localparam logic [7:0] HOLD_MAX = 8'(MIN_SEQ);
  localparam logic [3:0] GAP_MAX  = 4'(IDLE_GAP);

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d, req_mode;
  logic [7:0]  hold_q, hold_d, hold_inc;
  logic [3:0]  gap_q, gap_d, gap_inc;
  logic [31:0] data_q, data_d;
  logic        kchn_q, kchn_d;
  logic        und_q, und_d;
  logic        perr_q, perr_d;
  logic        frm_ready, accept;
  logic        frm_inc, prim_inc;
  logic [31:0] frm_cnt_q, prim_cnt_q;
  logic [31:0] frm_out_q, prim_out_q;

  function automatic logic [31:0] fill_word(input mode_e m);
    logic [31:0] w;
    w = W_IDLE;
    unique case (1'b1)
      (m == M_NOS): w = W_NOS;
      (m == M_OLS): w = W_OLS;
      (m == M_LR):  w = W_LR;
      (m == M_LRR): w = W_LRR;
      default:      w = W_IDLE;
    endcase
    return w;
  endfunction

  // Map the commanded mode; reserved codes fall back to NOS
  always_comb begin
    req_mode = M_NOS;
    unique case (iTX_MODE)
      3'd0:    req_mode = M_ACT;
      3'd2:    req_mode = M_OLS;
      3'd3:    req_mode = M_LR;
      3'd4:    req_mode = M_LRR;
      default: req_mode = M_NOS;
    endcase
  end

  assign frm_ready = (state_q == S_FRAME)
                   | ((mode_q == M_ACT)
                   & (gap_q == GAP_MAX)
                   & (req_mode == M_ACT));
  assign accept    = iFRM_VALID & frm_ready;

  assign hold_inc = (hold_q >= HOLD_MAX) ? HOLD_MAX
                                         : hold_q + 8'd1;
  assign gap_inc  = (gap_q >= GAP_MAX) ? GAP_MAX
                                       : gap_q + 4'd1;

  // Next word, state, mode and counter selection
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    hold_d   = hold_inc;
    gap_d    = gap_q;
    data_d   = W_IDLE;
    kchn_d   = 1'b1;
    und_d    = 1'b0;
    perr_d   = 1'b0;
    frm_inc  = 1'b0;
    prim_inc = 1'b0;
    if (state_q == S_FRAME) begin
      if (accept) begin
        data_d = iFRM_DATA;
        kchn_d = iFRM_KCHN;
        if (iFRM_EOF) begin
          state_d = S_FILL;
          gap_d   = '0;
          frm_inc = 1'b1;
        end
      end else begin
        und_d = 1'b1;
      end
    end else if (accept) begin
      if (iFRM_SOF) begin
        data_d  = iFRM_DATA;
        kchn_d  = iFRM_KCHN;
        state_d = S_FRAME;
      end else begin
        perr_d = 1'b1;
        gap_d  = gap_inc;
      end
    end else begin
      if ((hold_q >= HOLD_MAX) && (req_mode != mode_q)) begin
        mode_d   = req_mode;
        hold_d   = '0;
        prim_inc = (req_mode != M_ACT);
      end
      data_d = fill_word(mode_d);
      gap_d  = (mode_d == M_ACT) ? gap_inc : '0;
    end
  end

  // Transmit state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      mode_q  <= M_NOS;
      hold_q  <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      kchn_q  <= 1'b0;
      und_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      kchn_q  <= kchn_d;
      und_q   <= und_d;
      perr_q  <= perr_d;
    end
  end

  // Interval counters with latch-and-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt_q  <= '0;
      prim_cnt_q <= '0;
      frm_out_q  <= '0;
      prim_out_q <= '0;
    end else if (iSTATS_LATCH_CLR) begin
      frm_out_q  <= frm_cnt_q + {31'b0, frm_inc};
      prim_out_q <= prim_cnt_q + {31'b0, prim_inc};
      frm_cnt_q  <= '0;
      prim_cnt_q <= '0;
    end else begin
      frm_cnt_q  <= frm_cnt_q + {31'b0, frm_inc};
      prim_cnt_q <= prim_cnt_q + {31'b0, prim_inc};
    end
  end

  assign oFRM_READY             = frm_ready;
  assign oTX_DATA               = data_q;
  assign oTX_KCHN               = kchn_q;
  assign oFRM_UNDERRUN          = und_q;
  assign oFRM_PROTO_ERR         = perr_q;
  assign oINT_STATS_TX_FRAMES   = frm_out_q;
  assign oINT_STATS_TX_PRIM_SEQ = prim_out_q;

endmodule

// File: tb/tb_fc1_tx_ordered_set_gen.sv
`timescale 1ns/1ps
// Directed scoreboard bench for fc1_tx_ordered_set_gen.
// Frame words are predicted on acceptance and checked one cycle later.
module tb_fc1_tx_ordered_set_gen;

  localparam int GAP = 6;
  localparam int MSQ = 12;

  localparam logic [32:0] W_IDLE = {1'b1, 32'hBC95B5B5};
  localparam logic [32:0] W_NOS  = {1'b1, 32'hBC55BF45};
  localparam logic [32:0] W_OLS  = {1'b1, 32'hBC358A55};
  localparam logic [32:0] W_LR   = {1'b1, 32'hBC49BF49};
  localparam logic [32:0] W_LRR  = {1'b1, 32'hBC35BF49};

  typedef struct packed {
    logic [31:0] d;
    logic        k;
    logic        sof;
    logic        eof;
  } src_t;

  typedef struct packed {
    logic [31:0] d;
    logic        k;
    logic        und;
    logic        perr;
    logic        sof;
    logic        eof;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  iTX_MODE = 3'd1;
  logic        iFRM_VALID = 1'b0;
  logic [31:0] iFRM_DATA = '0;
  logic        iFRM_KCHN = 1'b0;
  logic        iFRM_SOF = 1'b0;
  logic        iFRM_EOF = 1'b0;
  logic        oFRM_READY;
  logic [31:0] oTX_DATA;
  logic        oTX_KCHN;
  logic        oFRM_UNDERRUN;
  logic        oFRM_PROTO_ERR;
  logic        iSTATS_LATCH_CLR = 1'b0;
  logic [31:0] oINT_STATS_TX_FRAMES;
  logic [31:0] oINT_STATS_TX_PRIM_SEQ;

  src_t src_q[$];
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  logic [2:0] md = 3'd1;
  bit src_en = 1'b1;
  bit lat_req = 1'b0;
  bit in_frm = 1'b0;
  bit exact_gap = 1'b0;
  bit post_eof_pend = 1'b0;
  int eof_acc = 0;
  int acc_cnt = 0;
  int latch_at_eof = 0;
  int und_cnt = 0;
  int perr_cnt = 0;
  int run_len = 0;
  int prev_run = 0;
  logic [32:0] cur_w = '0;
  logic [32:0] prev_w = '0;
  logic [32:0] post_eof_w = '0;

  fc1_tx_ordered_set_gen #(
    .IDLE_GAP(GAP),
    .MIN_SEQ(MSQ)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .iTX_MODE              (iTX_MODE),
    .iFRM_VALID            (iFRM_VALID),
    .iFRM_DATA             (iFRM_DATA),
    .iFRM_KCHN             (iFRM_KCHN),
    .iFRM_SOF              (iFRM_SOF),
    .iFRM_EOF              (iFRM_EOF),
    .oFRM_READY            (oFRM_READY),
    .oTX_DATA              (oTX_DATA),
    .oTX_KCHN              (oTX_KCHN),
    .oFRM_UNDERRUN         (oFRM_UNDERRUN),
    .oFRM_PROTO_ERR        (oFRM_PROTO_ERR),
    .iSTATS_LATCH_CLR      (iSTATS_LATCH_CLR),
    .oINT_STATS_TX_FRAMES  (oINT_STATS_TX_FRAMES),
    .oINT_STATS_TX_PRIM_SEQ(oINT_STATS_TX_PRIM_SEQ)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_fill(input logic [32:0] w);
    return (w === W_IDLE) || (w === W_NOS) || (w === W_OLS)
        || (w === W_LR) || (w === W_LRR);
  endfunction

  function automatic logic [35:0] all_out();
    return {oTX_DATA, oTX_KCHN, oFRM_READY,
            oFRM_UNDERRUN, oFRM_PROTO_ERR};
  endfunction

  function automatic logic [63:0] stats();
    return {oINT_STATS_TX_FRAMES, oINT_STATS_TX_PRIM_SEQ};
  endfunction

  task automatic push_frame(input int npay, input logic [31:0] base);
    src_q.push_back({32'hBCB55656, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < npay; i++)
      src_q.push_back({base + 32'(i), 1'b0, 1'b0, 1'b0});
    src_q.push_back({32'hBC957575, 1'b1, 1'b0, 1'b1});
  endtask

  task automatic mon();
    exp_t e;
    logic [32:0] w;
    w = {oTX_KCHN, oTX_DATA};
    if (w !== cur_w) begin
      prev_w = cur_w;
      prev_run = run_len;
      cur_w = w;
      run_len = 1;
    end else begin
      run_len++;
    end
    if (post_eof_pend) begin
      post_eof_w = w;
      post_eof_pend = 1'b0;
    end
    if (oFRM_UNDERRUN === 1'b1) und_cnt++;
    if (oFRM_PROTO_ERR === 1'b1) perr_cnt++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("tx_word", 64'(w), 64'({e.k, e.d}));
      chk("underrun", 64'(oFRM_UNDERRUN), 64'(e.und));
      chk("proto_err", 64'(oFRM_PROTO_ERR), 64'(e.perr));
      if (e.sof) begin
        chk("sof_gap_min",
            64'((prev_w === W_IDLE) && (prev_run >= GAP)), 64'(1));
        if (exact_gap)
          chk("sof_gap", 64'(prev_run), 64'(GAP));
      end
      if (e.eof) post_eof_pend = 1'b1;
    end else begin
      chk("fill_word", 64'(is_fill(w)), 64'(1));
      chk("no_pulse", 64'({oFRM_UNDERRUN, oFRM_PROTO_ERR}), 64'(0));
    end
  endtask

  task automatic drive();
    iTX_MODE = md;
    iSTATS_LATCH_CLR = lat_req;
    lat_req = 1'b0;
    if (src_en && src_q.size() > 0) begin
      iFRM_VALID = 1'b1;
      iFRM_DATA  = src_q[0].d;
      iFRM_KCHN  = src_q[0].k;
      iFRM_SOF   = src_q[0].sof;
      iFRM_EOF   = src_q[0].eof;
    end else begin
      iFRM_VALID = 1'b0;
      iFRM_DATA  = '0;
      iFRM_KCHN  = 1'b0;
      iFRM_SOF   = 1'b0;
      iFRM_EOF   = 1'b0;
    end
  endtask

  task automatic predict();
    src_t s;
    exp_t e;
    e = '0;
    if (iFRM_VALID && oFRM_READY) begin
      s = src_q.pop_front();
      acc_cnt++;
      if (in_frm) begin
        e.d = s.d;
        e.k = s.k;
        e.eof = s.eof;
        if (s.eof) begin
          in_frm = 1'b0;
          eof_acc++;
          if (eof_acc == latch_at_eof) iSTATS_LATCH_CLR = 1'b1;
        end
      end else if (s.sof) begin
        e.d = s.d;
        e.k = s.k;
        e.sof = 1'b1;
        in_frm = 1'b1;
      end else begin
        e.d = W_IDLE[31:0];
        e.k = 1'b1;
        e.perr = 1'b1;
      end
      sb.push_back(e);
    end else if (in_frm) begin
      e.d = W_IDLE[31:0];
      e.k = 1'b1;
      e.und = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    drive();
    #1;
    predict();
  endtask

  initial begin
    int a0;
    int u0;
    int p0;

    // reset with a frame already offered
    push_frame(3, 32'hA0000000);
    push_frame(3, 32'hA1000000);
    push_frame(3, 32'hA2000000);
    drive();
    repeat (3) begin
      @(negedge clk);
      chk("reset_out", 64'(all_out()), 64'(0));
    end
    chk("reset_stats", stats(), 64'(0));
    rst_n = 1'b1;
    drive();
    #1;
    predict();

    // NOS after reset, never ready
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("nos_word", 64'({oTX_KCHN, oTX_DATA}), 64'(W_NOS));
      chk("nos_ready", 64'(oFRM_READY), 64'(0));
    end
    chk("nos_stats", stats(), 64'(0));

    // NOS -> OLS
    md = 3'd2;
    for (int i = 0; i < 16; i++) cyc();
    chk("ols_word", 64'(cur_w), 64'(W_OLS));
    chk("ols_run", 64'(run_len), 64'(15));

    // OLS -> ACTIVE, three frames, latch on third EOF
    md = 3'd0;
    exact_gap = 1'b1;
    latch_at_eof = 3;
    for (int i = 0; i < 200 && eof_acc < 3; i++) cyc();
    chk("b_frames_done", 64'(eof_acc), 64'(3));
    cyc();
    chk("b_post_eof", 64'(post_eof_w), 64'(W_IDLE));
    chk("b_lat_frames", 64'(oINT_STATS_TX_FRAMES), 64'(3));
    chk("b_lat_prim", 64'(oINT_STATS_TX_PRIM_SEQ), 64'(1));
    exact_gap = 1'b0;
    latch_at_eof = 0;
    lat_req = 1'b1;
    cyc();
    cyc();
    chk("b_next_interval", stats(), 64'(0));

    // underrun: valid dropped two cycles mid-frame
    u0 = und_cnt;
    p0 = perr_cnt;
    a0 = acc_cnt;
    push_frame(3, 32'hC0000000);
    for (int i = 0; i < 100 && acc_cnt < a0 + 2; i++) cyc();
    chk("c_mid_frame", 64'(in_frm), 64'(1));
    src_en = 1'b0;
    cyc();
    cyc();
    src_en = 1'b1;
    for (int i = 0; i < 100 && src_q.size() > 0; i++) cyc();
    cyc();
    cyc();
    chk("c_underruns", 64'(und_cnt - u0), 64'(2));

    // protocol error: first word lacks SOF
    src_q.push_back({32'h11223344, 1'b0, 1'b0, 1'b0});
    push_frame(1, 32'hC1000000);
    for (int i = 0; i < 100 && src_q.size() > 0; i++) cyc();
    cyc();
    cyc();
    chk("c_proto_errs", 64'(perr_cnt - p0), 64'(1));
    chk("c_underruns_2", 64'(und_cnt - u0), 64'(2));
    lat_req = 1'b1;
    cyc();
    cyc();
    chk("c_lat_frames", 64'(oINT_STATS_TX_FRAMES), 64'(2));
    chk("c_lat_prim", 64'(oINT_STATS_TX_PRIM_SEQ), 64'(0));

    // LR requested mid-frame, LRR two cycles after LR starts
    a0 = acc_cnt;
    post_eof_w = '0;
    push_frame(2, 32'hD0000000);
    for (int i = 0; i < 100 && acc_cnt < a0 + 1; i++) cyc();
    md = 3'd3;
    for (int i = 0; i < 50 && cur_w !== W_LR; i++) cyc();
    chk("d_lr_seen", 64'(cur_w), 64'(W_LR));
    chk("d_post_eof", 64'(post_eof_w), 64'(W_LR));
    chk("d_frame_done", 64'(in_frm), 64'(0));
    cyc();
    cyc();
    md = 3'd4;
    for (int i = 0; i < 60 && cur_w !== W_LRR; i++) cyc();
    chk("d_lrr_seen", 64'(cur_w), 64'(W_LRR));
    chk("d_lr_before", 64'(prev_w), 64'(W_LR));
    chk("d_lr_min", 64'(prev_run >= MSQ), 64'(1));
    chk("d_lr_max", 64'(prev_run <= MSQ + 1), 64'(1));
    repeat (14) cyc();
    chk("d_lrr_hold", 64'(cur_w), 64'(W_LRR));
    lat_req = 1'b1;
    cyc();
    cyc();
    chk("d_lat_frames", 64'(oINT_STATS_TX_FRAMES), 64'(1));
    chk("d_lat_prim", 64'(oINT_STATS_TX_PRIM_SEQ), 64'(2));

    // asynchronous reset in the middle of a frame
    md = 3'd0;
    a0 = acc_cnt;
    push_frame(3, 32'hE0000000);
    for (int i = 0; i < 200 && acc_cnt < a0 + 2; i++) cyc();
    chk("e_mid_frame", 64'(in_frm), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_async_out", 64'(all_out()), 64'(0));
    chk("e_async_stats", stats(), 64'(0));
    src_q.delete();
    sb.delete();
    in_frm = 1'b0;
    post_eof_pend = 1'b0;
    md = 3'd1;
    drive();
    repeat (2) begin
      @(negedge clk);
      chk("e_reset_out", 64'(all_out()), 64'(0));
    end
    rst_n = 1'b1;
    drive();
    #1;
    predict();
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("e_nos_word", 64'({oTX_KCHN, oTX_DATA}), 64'(W_NOS));
    end
    lat_req = 1'b1;
    cyc();
    cyc();
    chk("e_stats", stats(), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
